// File: rtl/squash_subband_buffer.sv
`default_nettype none
// ============================================================================
// Module  : squash_subband_buffer
// Brief   : Ping-pong line buffer; replays (L,H) pairs as an L band then an H band.
// Revision: 1.0
// ============================================================================
module squash_subband_buffer #(
  parameter int DATA_W     = 8,
  parameter int LINE_PAIRS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_L,
  input  logic [DATA_W-1:0] in_H,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_band,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int IDX_W = $clog2(LINE_PAIRS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] C_WR_LAST = IDX_W'(LINE_PAIRS - 1);
  localparam logic [CNT_W-1:0] C_RD_LAST = CNT_W'(2 * LINE_PAIRS - 1);

  logic [DATA_W-1:0] r_mem_l [0:1][0:LINE_PAIRS-1];
  logic [DATA_W-1:0] r_mem_h [0:1][0:LINE_PAIRS-1];

  logic [1:0]       r_full;
  logic             r_wbank;
  logic             r_rbank;
  logic [IDX_W-1:0] r_wr_idx;
  logic [CNT_W-1:0] r_rd_cnt;

  logic             w_accept;
  logic             w_xfer;
  logic             w_wr_last;
  logic             w_rd_last;
  logic             w_band;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_full_nxt;

  assign in_ready  = !r_full[r_wbank];
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = out_valid && out_ready;
  assign w_wr_last = (r_wr_idx == C_WR_LAST);
  assign w_rd_last = (r_rd_cnt == C_RD_LAST);
  assign w_band    = r_rd_cnt[CNT_W-1];
  assign w_idx     = r_rd_cnt[IDX_W-1:0];

  // Writer only touches a non-full bank and reader only a full one, so the
  // set and clear below never target the same flag.
  always_comb begin
    w_full_nxt = r_full;
    if (w_accept && w_wr_last) w_full_nxt[r_wbank] = 1'b1;
    if (w_xfer && w_rd_last)   w_full_nxt[r_rbank] = 1'b0;
  end

  always_comb begin
    out_valid = r_full[r_rbank];
    out_data  = '0;
    if (out_valid) out_data = w_band ? r_mem_h[r_rbank][w_idx] : r_mem_l[r_rbank][w_idx];
    out_band  = w_band && out_valid;
    out_last  = out_valid && w_rd_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full   <= 2'b00;
      r_wbank  <= 1'b0;
      r_rbank  <= 1'b0;
      r_wr_idx <= '0;
      r_rd_cnt <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        r_wr_idx <= w_wr_last ? '0 : r_wr_idx + IDX_W'(1);
        if (w_wr_last) r_wbank <= ~r_wbank;
      end
      if (w_xfer) begin
        r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + CNT_W'(1);
        if (w_rd_last) r_rbank <= ~r_rbank;
      end
    end
  end

  // Coefficient storage carries no reset; partial lines are simply overwritten.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_l[r_wbank][r_wr_idx] <= in_L;
      r_mem_h[r_wbank][r_wr_idx] <= in_H;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_squash_subband_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_squash_subband_buffer
// Brief   : Directed self-checking bench for squash_subband_buffer.
// Revision: 1.0
// ============================================================================
module tb_squash_subband_buffer;

  localparam int DW = 8;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_L = '0;
  logic [DW-1:0] in_H = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_band;
  logic          out_last;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_d [0:7];
  bit saw_stall = 1'b0;

  squash_subband_buffer #(.DATA_W(DW), .LINE_PAIRS(NP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_L      (in_L),
    .in_H      (in_H),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_band  (out_band),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fl(input int k, input int p);
    return 8'(k * 16 + p + 1);
  endfunction

  function automatic logic [7:0] fh(input int k, input int p);
    return 8'(128 + k * 16 + p + 1);
  endfunction

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic push(input logic [7:0] l, input logic [7:0] h);
    int t = 0;
    in_valid = 1'b1;
    in_L = l;
    in_H = h;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 1);
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 1);
  endtask

  task automatic drain(input string tag, input bit ir_chk);
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      wait_valid();
      chk({tag, "_data"}, 32'(out_data), 32'(exp_d[b]));
      chk({tag, "_band"}, 32'(out_band), 32'(b >= 4));
      chk({tag, "_last"}, 32'(out_last), 32'(b == 7));
      if (ir_chk) chk({tag, "_ir_low"}, 32'(in_ready), 0);
      @(negedge clk);
    end
    if (ir_chk) chk({tag, "_ir_back"}, 32'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  task automatic load_exp(input logic [7:0] l0, l1, l2, l3, h0, h1, h2, h3);
    exp_d[0] = l0; exp_d[1] = l1; exp_d[2] = l2; exp_d[3] = l3;
    exp_d[4] = h0; exp_d[5] = h1; exp_d[6] = h2; exp_d[7] = h3;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single line, latency and ordering
    out_ready = 1'b1;
    push(10, 1); push(20, 2); push(30, 3);
    chk("s1_not_yet", 32'(out_valid), 0);
    push(40, 4);
    in_valid = 1'b0;
    chk("s1_latency", 32'(out_valid), 1);
    load_exp(10, 20, 30, 40, 1, 2, 3, 4);
    drain("s1", 1'b0);

    // 2: three continuous lines through both banks
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 3; k++)
          for (int p = 0; p < NP; p++) push(fl(k, p), fh(k, p));
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++)
          for (int b = 0; b < 8; b++) begin
            wait_valid();
            chk("s2_data", 32'(out_data), 32'((b < 4) ? fl(k, b) : fh(k, b - 4)));
            chk("s2_band", 32'(out_band), 32'(b >= 4));
            chk("s2_last", 32'(out_last), 32'(b == 7));
            if (!in_ready) saw_stall = 1'b1;
            @(negedge clk);
          end
      end
    join
    chk("s2_in_stall_seen", 32'(saw_stall), 1);
    out_ready = 1'b0;
    @(negedge clk);

    // 3: both banks full, extra pair ignored
    for (int k = 4; k < 6; k++)
      for (int p = 0; p < NP; p++) push(fl(k, p), fh(k, p));
    in_valid = 1'b0;
    chk("s3_ir_full", 32'(in_ready), 0);
    in_valid = 1'b1; in_L = 99; in_H = 99;
    @(negedge clk);
    in_valid = 1'b0;
    chk("s3_ir_still", 32'(in_ready), 0);
    load_exp(fl(4,0), fl(4,1), fl(4,2), fl(4,3), fh(4,0), fh(4,1), fh(4,2), fh(4,3));
    drain("s3a", 1'b1);
    load_exp(fl(5,0), fl(5,1), fl(5,2), fl(5,3), fh(5,0), fh(5,1), fh(5,2), fh(5,3));
    drain("s3b", 1'b0);

    // 4: out_ready toggling; outputs hold through stalls
    push(10, 1); push(20, 2); push(30, 3); push(40, 4);
    in_valid = 1'b0;
    load_exp(10, 20, 30, 40, 1, 2, 3, 4);
    begin
      int e = 0;
      int t = 0;
      while (e < 8 && t < 60) begin
        out_ready = t[0];
        chk("s4_valid", 32'(out_valid), 1);
        chk("s4_data", 32'(out_data), 32'(exp_d[e]));
        chk("s4_band", 32'(out_band), 32'(e >= 4));
        chk("s4_last", 32'(out_last), 32'(e == 7));
        if (out_ready) e++;
        @(negedge clk);
        t++;
      end
      chk("s4_done", 32'(e), 8);
    end
    out_ready = 1'b0;

    // 5: async reset mid-readout with a partial line pending
    push(10, 1); push(20, 2); push(30, 3); push(40, 4);
    out_ready = 1'b1;
    push(50, 60); push(51, 61);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("s5_mid", 32'(out_data), 30);
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_valid", 32'(out_valid), 0);
    chk("s5_rst_data", 32'(out_data), 0);
    chk("s5_rst_band", 32'(out_band), 0);
    chk("s5_rst_last", 32'(out_last), 0);
    chk("s5_rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    push(5, 6); push(7, 8); push(9, 10); push(11, 12);
    in_valid = 1'b0;
    load_exp(5, 7, 9, 11, 6, 8, 10, 12);
    drain("s5", 1'b0);

    // 6: extreme coefficient values
    push(255, 0); push(0, 255); push(128, 127); push(1, 254);
    in_valid = 1'b0;
    load_exp(255, 0, 128, 1, 0, 255, 127, 254);
    drain("s6", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/squash_subband_buffer.md
Name: squash_subband_buffer

Overview:
- Downstream stage of the lifting-wavelet squash stage; consumes its interleaved low/high coefficient pairs.
- Collects one line of LINE_PAIRS (L,H) pairs into a ping-pong bank.
- Replays the bank as a deinterleaved stream: all L coefficients first, then all H coefficients.
- The L-band stream feeds the next decomposition level; the H-band stream feeds the coefficient coder.

Parameters:
DATA_W, 8, coefficient width in bits
LINE_PAIRS, 4, (L,H) pairs per line; power of two, 2..256

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_L/in_H carry a coefficient pair
in_L  in  DATA_W  low-band coefficient
in_H  in  DATA_W  high-band coefficient
in_ready  out  1  buffer accepts a pair this cycle
out_valid  out  1  out_data is valid
out_data  out  DATA_W  deinterleaved coefficient
out_band  out  1  0 = L band, 1 = H band
out_last  out  1  final beat of the line (last H coefficient)
out_ready  in  1  consumer accepts the beat

Behaviour:
- Storage: 2 banks (0/1). Each bank holds LINE_PAIRS L words and LINE_PAIRS H words, plus a full flag.
- Write side: wbank (1 bit), wr_idx (log2 LINE_PAIRS bits).
  - in_ready = !full[wbank], combinational.
  - On in_valid && in_ready: store L[wbank][wr_idx] = in_L and H[wbank][wr_idx] = in_H, then increment wr_idx.
  - When wr_idx == LINE_PAIRS-1 at accept: set full[wbank], wr_idx wraps to 0, wbank toggles.
- Read side: rbank (1 bit), rd_cnt (log2(2*LINE_PAIRS) bits).
  - out_valid = full[rbank].
  - Beat index: band = rd_cnt MSB, idx = rd_cnt low bits.
  - out_data = band ? H[rbank][idx] : L[rbank][idx], combinational from storage; 0 when !out_valid.
  - out_band = band && out_valid.
  - out_last = out_valid && rd_cnt == 2*LINE_PAIRS-1.
- Read transfer (out_valid && out_ready): rd_cnt increments.
  - On the last beat: rd_cnt wraps to 0, full[rbank] clears, rbank toggles.
- Output ordering per line: L0..L(N-1), then H0..H(N-1). Exactly 2*LINE_PAIRS beats.
- Latency: out_valid rises the cycle after the accept of the line's final pair. Minimum first-pair-in to first-beat-out is LINE_PAIRS cycles.
- Throughput: input 1 pair/cycle, output 1 word/cycle. In steady state the input stalls for LINE_PAIRS of every 2*LINE_PAIRS cycles.
- Both banks full: in_ready = 0; wr_idx and storage are held.
- Simultaneous events: a write into wbank and a read completion on rbank in the same cycle touch different banks.
  - Both full-flag updates take effect; neither is lost.
  - A bank freed this cycle is writable from the next cycle only, because in_ready is derived from the registered flag.
- Backpressure: while out_valid && !out_ready, out_data, out_band and out_last are stable. rd_cnt is held.
- in_valid while in_ready = 0: the pair is ignored; no write, no index change.
- Reset (async assert, any time including mid-line):
  - wbank, rbank, wr_idx, rd_cnt and full[1:0] all clear to 0.
  - Outputs immediately: out_valid 0, out_data 0, out_band 0, out_last 0, in_ready 1.
  - Storage contents are don't-care; partial lines are discarded.
- Coefficients are stored and replayed bit-exact; there is no arithmetic on data.

Test Plan:
1. Reset then 4 pairs (L,H) = (10,1),(20,2),(30,3),(40,4) on consecutive cycles, out_ready=1 -> out_valid rises the cycle after pair 4. Beats are 10,20,30,40 with band 0, then 1,2,3,4 with band 1. out_last is high only on the beat carrying 4.
2. Continuous input of 3 lines, out_ready=1 -> in_ready toggles so both banks alternate. All 24 beats arrive in order with no loss or duplicates.
3. out_ready=0 while 2 lines are written -> in_ready falls after the 8th pair, and a 9th pair (99,99) is ignored. Setting out_ready=1 drains line 1 then line 2 unchanged; in_ready returns the cycle after line 1's out_last.
4. out_ready toggled 1/0 each cycle during readout -> out_data and out_band hold during stall cycles. The sequence matches scenario 1.
5. Assert rst after 2 pairs of line 2 while line 1 is mid-readout -> outputs are 0 and in_ready is 1 immediately. Next line (5,6),(7,8),(9,10),(11,12) replays as 5,7,9,11,6,8,10,12.
6. Edge values: pairs (255,0),(0,255),(128,127),(1,254) -> replayed bit-exact, e.g. L beats 255,0,128,1.
